// File: rtl/plot_buffer.sv
// plot_buffer: pixel FIFO between a drawing engine and a VGA adapter.
//
// Accepts one pixel per in_plot cycle, discards off-screen pixels (counted in
// clip_count), buffers up to DEPTH pixels and forwards them in order through a
// registered output stage whenever the adapter signals out_ready.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_x/in_y/in_colour/in_plot   pixel input from the drawing engine
//   out_ready                     adapter can accept a write this cycle
//   flush                         synchronous discard of all buffered pixels
//   vga_x/vga_y/vga_colour/vga_plot  registered pixel write to the adapter
//   full                          FIFO holds DEPTH pixels
//   busy                          pixels buffered or a write in flight
//   overflow                      sticky: an on-screen pixel was dropped
//   clip_count                    saturating count of off-screen pixels
module plot_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       in_plot,
    input  logic       out_ready,
    input  logic       flush,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] clip_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [8:0]    X_LIM   = 9'(SCREEN_W);
    localparam logic [7:0]    Y_LIM   = 8'(SCREEN_H);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      clip_q, clip_d;
    logic            vplot_q, vplot_d;
    logic [17:0]     pix_q, pix_d;
    logic [17:0]     mem_q [DEPTH];

    logic in_bounds, pop, push, lose, clip;

    always_comb begin
        in_bounds = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
        pop       = (state_q != EMPTY) && out_ready && !flush;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = in_plot && in_bounds && !flush && ((state_q != FULL) || pop);
        lose      = in_plot && in_bounds && !flush && (state_q == FULL) && !pop;
        clip      = in_plot && !in_bounds && !flush;

        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q | lose;
        clip_d   = clip_q;
        vplot_d  = pop;
        pix_d    = pix_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            pix_d    = mem_q[rd_ptr_q];
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clip && (clip_q != 8'hFF)) begin
            clip_d = clip_q + 8'd1;
        end

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
            clip_d   = '0;
            vplot_d  = 1'b0;
        end

        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (count_d == DEPTH_C) begin
            state_d = FULL;
        end else begin
            state_d = FILLING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            clip_q   <= '0;
            vplot_q  <= 1'b0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            clip_q   <= clip_d;
            vplot_q  <= vplot_d;
            pix_q    <= pix_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
        end
    end

    assign vga_x      = pix_q[17:10];
    assign vga_y      = pix_q[9:3];
    assign vga_colour = pix_q[2:0];
    assign vga_plot   = vplot_q;
    assign full       = (count_q == DEPTH_C);
    assign busy       = (count_q != '0) || vplot_q;
    assign overflow   = ovf_q;
    assign clip_count = clip_q;

endmodule
